// File: rtl/turf_udp_pkg.sv
// Shared definitions for the TURF UDP receive-side blocks: header layout, port map base
// and the demux state encoding.
package turf_udp_pkg;

  localparam int unsigned UDPHDR_W  = 64;
  localparam int unsigned UDPDATA_W = 64;
  localparam int unsigned UDPKEEP_W = 8;
  localparam int unsigned UDPPORT_W = 16;

  localparam int unsigned UDPHDR_SRCIP_LSB   = 32;
  localparam int unsigned UDPHDR_SRCPORT_LSB = 16;
  localparam int unsigned UDPHDR_LEN_LSB     = 0;

  localparam logic [UDPPORT_W-1:0] TURF_UDP_PORT_BASE = 16'h5400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_e;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] len;
  } udphdr_t;

  // Split a raw header word into its fields.
  function automatic udphdr_t udphdr_unpack(input logic [UDPHDR_W-1:0] tdata);
    udphdr_t h;
    h.src_ip   = tdata[UDPHDR_SRCIP_LSB +: 32];
    h.src_port = tdata[UDPHDR_SRCPORT_LSB +: 16];
    h.len      = tdata[UDPHDR_LEN_LSB +: 16];
    return h;
  endfunction

endpackage

// File: rtl/turf_udp_port_demux.sv
// Steers each received UDP datagram (header + payload) to one consumer chosen by
// destination port; datagrams to unmapped ports are sunk and counted.
module turf_udp_port_demux
  import turf_udp_pkg::*;
#(
  parameter int unsigned          NUM_PORTS = 4,
  parameter logic [UDPPORT_W-1:0] PORT_BASE = TURF_UDP_PORT_BASE,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UDPHDR_W-1:0]    s_udphdr_tdata,
  input  logic [UDPPORT_W-1:0]   s_udphdr_tdest,
  input  logic                   s_udphdr_tvalid,
  output logic                   s_udphdr_tready,
  input  logic [UDPDATA_W-1:0]   s_udpdata_tdata,
  input  logic [UDPKEEP_W-1:0]   s_udpdata_tkeep,
  input  logic                   s_udpdata_tlast,
  input  logic                   s_udpdata_tvalid,
  output logic                   s_udpdata_tready,
  output logic [UDPHDR_W-1:0]    m_udphdr_tdata,
  output logic [NUM_PORTS-1:0]   m_udphdr_tvalid,
  input  logic [NUM_PORTS-1:0]   m_udphdr_tready,
  output logic [UDPDATA_W-1:0]   m_udpdata_tdata,
  output logic [UDPKEEP_W-1:0]   m_udpdata_tkeep,
  output logic                   m_udpdata_tlast,
  output logic [NUM_PORTS-1:0]   m_udpdata_tvalid,
  input  logic [NUM_PORTS-1:0]   m_udpdata_tready,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic [CNT_WIDTH-1:0]   fwd_count
);

  localparam int unsigned SEL_W = 3;

  demux_state_e           state, state_nxt;
  logic [NUM_PORTS-1:0]   sel_oh, sel_oh_nxt;
  logic                   hdr_pend, hdr_pend_nxt;
  logic                   data_done, data_done_nxt;
  logic                   hdr_rdy_nxt;
  udphdr_t                hdr_q, hdr_q_nxt;
  logic                   drop_inc, fwd_inc;
  logic [UDPPORT_W-1:0]   idx;
  logic                   hit;
  logic                   hdr_fire;
  logic                   hdr_taken;
  logic                   hdr_done;
  logic                   last_fire;

  // Payload is a shared pass-through; only the one-hot valids select the consumer.
  assign m_udpdata_tdata = s_udpdata_tdata;
  assign m_udpdata_tkeep = s_udpdata_tkeep;
  assign m_udpdata_tlast = s_udpdata_tlast;
  assign m_udphdr_tdata  = hdr_q;

  always_comb begin
    state_nxt        = state;
    sel_oh_nxt       = sel_oh;
    hdr_pend_nxt     = hdr_pend;
    data_done_nxt    = data_done;
    hdr_q_nxt        = hdr_q;
    drop_inc         = 1'b0;
    fwd_inc          = 1'b0;
    s_udpdata_tready = 1'b0;
    m_udphdr_tvalid  = '0;
    m_udpdata_tvalid = '0;
    hdr_taken        = 1'b0;
    hdr_done         = 1'b0;
    last_fire        = 1'b0;
    idx              = s_udphdr_tdest - PORT_BASE;
    hit              = (s_udphdr_tdest >= PORT_BASE) && (idx < UDPPORT_W'(NUM_PORTS));
    hdr_fire         = s_udphdr_tvalid && s_udphdr_tready;

    case (state)
      IDLE: begin
        if (hdr_fire) begin
          hdr_q_nxt  = udphdr_unpack(s_udphdr_tdata);
          sel_oh_nxt = NUM_PORTS'(1) << SEL_W'(idx);
          if (hit) begin
            state_nxt     = FWD;
            hdr_pend_nxt  = 1'b1;
            data_done_nxt = 1'b0;
          end else begin
            state_nxt = DROP;
            drop_inc  = 1'b1;
          end
        end
      end

      FWD: begin
        m_udphdr_tvalid  = hdr_pend ? sel_oh : '0;
        m_udpdata_tvalid = (s_udpdata_tvalid && !data_done) ? sel_oh : '0;
        s_udpdata_tready = (|(m_udpdata_tready & sel_oh)) && !data_done;
        hdr_taken        = |(m_udphdr_tready & sel_oh);
        hdr_done         = !hdr_pend || hdr_taken;
        last_fire        = s_udpdata_tvalid && s_udpdata_tready && s_udpdata_tlast;
        if (hdr_taken) hdr_pend_nxt = 1'b0;
        if (last_fire) data_done_nxt = 1'b1;
        // Header and payload finish independently; leave only once both are through.
        if (hdr_done && (data_done || last_fire)) begin
          state_nxt = IDLE;
          fwd_inc   = 1'b1;
        end
      end

      DROP: begin
        s_udpdata_tready = 1'b1;
        if (s_udpdata_tvalid && s_udpdata_tlast) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    hdr_rdy_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      sel_oh          <= '0;
      hdr_pend        <= 1'b0;
      data_done       <= 1'b0;
      hdr_q           <= '0;
      s_udphdr_tready <= 1'b0;
    end else begin
      state           <= state_nxt;
      sel_oh          <= sel_oh_nxt;
      hdr_pend        <= hdr_pend_nxt;
      data_done       <= data_done_nxt;
      hdr_q           <= hdr_q_nxt;
      s_udphdr_tready <= hdr_rdy_nxt;
    end
  end

  // Saturating datagram counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      fwd_count  <= '0;
    end else begin
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
      if (fwd_inc && (fwd_count != '1))   fwd_count  <= fwd_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_turf_udp_port_demux.sv
// Directed bench for turf_udp_port_demux with a per-beat scoreboard; a second instance with
// 2-bit counters shares all stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_turf_udp_port_demux;

  localparam int unsigned NP  = 4;
  localparam int unsigned TMO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]   s_udphdr_tdata = '0;
  logic [15:0]   s_udphdr_tdest = '0;
  logic          s_udphdr_tvalid = 1'b0;
  logic          s_udphdr_tready;
  logic [63:0]   s_udpdata_tdata = '0;
  logic [7:0]    s_udpdata_tkeep = '0;
  logic          s_udpdata_tlast = 1'b0;
  logic          s_udpdata_tvalid = 1'b0;
  logic          s_udpdata_tready;
  logic [63:0]   m_udphdr_tdata;
  logic [NP-1:0] m_udphdr_tvalid;
  logic [NP-1:0] m_udphdr_tready = '1;
  logic [63:0]   m_udpdata_tdata;
  logic [7:0]    m_udpdata_tkeep;
  logic          m_udpdata_tlast;
  logic [NP-1:0] m_udpdata_tvalid;
  logic [NP-1:0] m_udpdata_tready = '1;
  logic [15:0]   drop_count;
  logic [15:0]   fwd_count;

  logic          s_udphdr_tready_b;
  logic          s_udpdata_tready_b;
  logic [63:0]   m_udphdr_tdata_b;
  logic [NP-1:0] m_udphdr_tvalid_b;
  logic [63:0]   m_udpdata_tdata_b;
  logic [7:0]    m_udpdata_tkeep_b;
  logic          m_udpdata_tlast_b;
  logic [NP-1:0] m_udpdata_tvalid_b;
  logic [1:0]    drop_count_b;
  logic [1:0]    fwd_count_b;

  turf_udp_port_demux #(.NUM_PORTS(NP), .PORT_BASE(16'h5400), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
    .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
    .s_udpdata_tready(s_udpdata_tready),
    .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid),
    .m_udphdr_tready(m_udphdr_tready),
    .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep),
    .m_udpdata_tlast(m_udpdata_tlast), .m_udpdata_tvalid(m_udpdata_tvalid),
    .m_udpdata_tready(m_udpdata_tready),
    .drop_count(drop_count), .fwd_count(fwd_count)
  );

  turf_udp_port_demux #(.NUM_PORTS(NP), .PORT_BASE(16'h5400), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready_b),
    .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
    .s_udpdata_tready(s_udpdata_tready_b),
    .m_udphdr_tdata(m_udphdr_tdata_b), .m_udphdr_tvalid(m_udphdr_tvalid_b),
    .m_udphdr_tready(m_udphdr_tready),
    .m_udpdata_tdata(m_udpdata_tdata_b), .m_udpdata_tkeep(m_udpdata_tkeep_b),
    .m_udpdata_tlast(m_udpdata_tlast_b), .m_udpdata_tvalid(m_udpdata_tvalid_b),
    .m_udpdata_tready(m_udpdata_tready),
    .drop_count(drop_count_b), .fwd_count(fwd_count_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          port;
    logic [63:0] hdr;
  } hexp_t;

  beat_t exp_beats[$];
  hexp_t exp_hdrs[$];
  beat_t eb;
  hexp_t eh;

  // Consumer-side ready generation: fixed masks or random backpressure.
  logic          rand_bp = 1'b0;
  logic [NP-1:0] hdr_rdy_fix = '1;
  logic [NP-1:0] dat_rdy_fix = '1;

  always @(posedge clk) begin
    #1;
    if (rand_bp) begin
      m_udphdr_tready  = NP'($urandom);
      m_udpdata_tready = NP'($urandom);
    end else begin
      m_udphdr_tready  = hdr_rdy_fix;
      m_udpdata_tready = dat_rdy_fix;
    end
  end

  // Scoreboard monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
  logic [NP-1:0] prev_hv = '0;
  logic [63:0]   prev_hd = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hv != '0) begin
        check("hdr_hold_valid", 64'(m_udphdr_tvalid), 64'(prev_hv));
        check("hdr_hold_data", m_udphdr_tdata, prev_hd);
      end
      if (m_udpdata_tvalid != '0)
        check("dat_onehot", 64'($countones(m_udpdata_tvalid)), 64'd1);
      for (int i = 0; i < NP; i++) begin
        if (m_udphdr_tvalid[i] && m_udphdr_tready[i]) begin
          if (exp_hdrs.size() == 0) begin
            check("hdr_unexpected", 64'(i), 64'hFFFF);
          end else begin
            eh = exp_hdrs.pop_front();
            check("hdr_port", 64'(i), 64'(eh.port));
            check("hdr_data", m_udphdr_tdata, eh.hdr);
          end
        end
        if (m_udpdata_tvalid[i] && m_udpdata_tready[i]) begin
          if (exp_beats.size() == 0) begin
            check("beat_unexpected", 64'(i), 64'hFFFF);
          end else begin
            eb = exp_beats.pop_front();
            check("beat_port", 64'(i), 64'(eb.port));
            check("beat_data", m_udpdata_tdata, eb.data);
            check("beat_keep", 64'(m_udpdata_tkeep), 64'(eb.keep));
            check("beat_last", 64'(m_udpdata_tlast), 64'(eb.last));
          end
        end
      end
      prev_hv = m_udphdr_tvalid & ~m_udphdr_tready;
      prev_hd = m_udphdr_tdata;
    end else begin
      prev_hv = '0;
    end
  end

  task automatic send_dgram(input logic [15:0] dest, input logic [63:0] hdr, input int nbeats,
                            input logic zero_len, input logic gaps);
    int          port;
    logic        mapped;
    logic [63:0] d[8];
    logic [7:0]  k[8];
    beat_t       b;
    hexp_t       h;
    port   = int'(dest) - int'(16'h5400);
    mapped = (port >= 0) && (port < int'(NP));
    for (int i = 0; i < nbeats; i++) begin
      d[i] = {$urandom, $urandom};
      if (i != nbeats - 1) k[i] = 8'hFF;
      else if (zero_len)   k[i] = 8'h00;
      else                 k[i] = 8'(8'hFF >> $urandom_range(0, 7));
    end
    if (mapped) begin
      h.port = port;
      h.hdr  = hdr;
      exp_hdrs.push_back(h);
      for (int i = 0; i < nbeats; i++) begin
        b.port = port; b.data = d[i]; b.keep = k[i]; b.last = (i == nbeats - 1);
        exp_beats.push_back(b);
      end
    end
    fork
      begin : hdr_side
        int n;
        @(posedge clk); #1;
        s_udphdr_tdata  = hdr;
        s_udphdr_tdest  = dest;
        s_udphdr_tvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_udphdr_tready && n < int'(TMO));
        if (n >= int'(TMO)) check("hdr_in_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_udphdr_tvalid = 1'b0;
        check("hdr_latency", 64'(m_udphdr_tvalid), mapped ? 64'(NP'(1) << port) : 64'd0);
        if (!mapped) check("drop_no_dvalid", 64'(m_udpdata_tvalid), 64'd0);
      end
      begin : dat_side
        int n;
        for (int i = 0; i < nbeats; i++) begin
          @(posedge clk); #1;
          if (gaps) begin
            s_udpdata_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          s_udpdata_tdata  = d[i];
          s_udpdata_tkeep  = k[i];
          s_udpdata_tlast  = (i == nbeats - 1);
          s_udpdata_tvalid = 1'b1;
          n = 0;
          while (1) begin
            @(negedge clk);
            if (s_udpdata_tready) break;
            n++;
            if (n > int'(TMO)) begin check("dat_in_timeout", 64'd0, 64'd1); break; end
          end
        end
        @(posedge clk); #1;
        s_udpdata_tvalid = 1'b0;
        s_udpdata_tlast  = 1'b0;
      end
    join
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_udphdr_tready && n < int'(TMO));
    if (n >= int'(TMO)) check(tag, 64'd0, 64'd1);
  endtask

  task automatic check_sb_empty(input string tag);
    check(tag, 64'(exp_beats.size() + exp_hdrs.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int p;
    logic zl;

    // Reset values
    #2;
    check("rst_hdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
    check("rst_dat_tvalid", 64'(m_udpdata_tvalid), 64'd0);
    check("rst_hdr_tready", 64'(s_udphdr_tready), 64'd0);
    check("rst_dat_tready", 64'(s_udpdata_tready), 64'd0);
    check("rst_hdr_tdata", m_udphdr_tdata, 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_fwd", 64'(fwd_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("idle_after_rst");

    // 1: three beats to consumer 1, everyone ready
    send_dgram(16'h5401, 64'hC0A8_0001_1234_0018, 3, 1'b0, 1'b0);
    wait_idle("idle_t1");
    check("t1_fwd", 64'(fwd_count), 64'd1);
    check_sb_empty("t1_sb_empty");

    // 2: unmapped ports just above and just below the window
    send_dgram(16'h5404, 64'h0A00_0002_AAAA_0010, 2, 1'b0, 1'b0);
    wait_idle("idle_t2a");
    send_dgram(16'h53FF, 64'h0A00_0003_BBBB_0010, 2, 1'b0, 1'b0);
    wait_idle("idle_t2b");
    check("t2_drop", 64'(drop_count), 64'd2);
    check("t2_fwd", 64'(fwd_count), 64'd1);

    // 3: header stalled at consumer 2 while payload completes
    hdr_rdy_fix = 4'b1011;
    repeat (2) @(posedge clk);
    send_dgram(16'h5402, 64'h0A00_0004_CCCC_0020, 3, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_stuck_fwd", 64'(s_udphdr_tready), 64'd0);
    check("t3_hdr_pending", 64'(m_udphdr_tvalid), 64'b0100);
    check("t3_no_beats_left", 64'(exp_beats.size()), 64'd0);
    check("t3_fwd_before", 64'(fwd_count), 64'd1);
    hdr_rdy_fix = '1;
    wait_idle("idle_t3");
    check("t3_fwd_after", 64'(fwd_count), 64'd2);
    check_sb_empty("t3_sb_empty");

    // 4: random backpressure, 200 datagrams over the mapped window
    rand_bp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      p  = $urandom_range(0, NP - 1);
      nb = $urandom_range(1, 4);
      zl = (nb == 1) && ($urandom_range(0, 3) == 0);
      send_dgram(16'(16'h5400 + p), {$urandom, $urandom}, nb, zl, 1'b1);
      wait_idle("idle_t4");
    end
    rand_bp = 1'b0;
    repeat (2) @(posedge clk);
    check("t4_fwd", 64'(fwd_count), 64'd202);
    check("t4_drop", 64'(drop_count), 64'd2);
    check_sb_empty("t4_sb_empty");
    check("sat_fwd", 64'(fwd_count_b), 64'd3);

    // 5: three more unmapped datagrams saturate the narrow counter
    send_dgram(16'hFFFF, 64'h1, 2, 1'b0, 1'b0);
    wait_idle("idle_t5a");
    check("sat_drop_3", 64'(drop_count_b), 64'd3);
    send_dgram(16'h0000, 64'h2, 1, 1'b1, 1'b0);
    wait_idle("idle_t5b");
    send_dgram(16'h5408, 64'h3, 2, 1'b0, 1'b0);
    wait_idle("idle_t5c");
    check("sat_drop_hold", 64'(drop_count_b), 64'd3);
    check("t5_drop", 64'(drop_count), 64'd5);

    // 6: reset while a datagram is parked in FWD
    hdr_rdy_fix = '0;
    dat_rdy_fix = '0;
    repeat (2) @(posedge clk);
    #1;
    s_udphdr_tdata  = 64'hDEAD_BEEF_0001_0008;
    s_udphdr_tdest  = 16'h5400;
    s_udphdr_tvalid = 1'b1;
    wait_idle("t6_hdr_in");
    @(posedge clk); #1;
    s_udphdr_tvalid  = 1'b0;
    s_udpdata_tvalid = 1'b1;
    s_udpdata_tlast  = 1'b0;
    @(posedge clk); #1;
    check("t6_pre_hvalid", 64'(m_udphdr_tvalid), 64'b0001);
    check("t6_pre_dvalid", 64'(m_udpdata_tvalid), 64'b0001);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hvalid", 64'(m_udphdr_tvalid), 64'd0);
    check("t6_rst_dvalid", 64'(m_udpdata_tvalid), 64'd0);
    check("t6_rst_hready", 64'(s_udphdr_tready), 64'd0);
    check("t6_rst_dready", 64'(s_udpdata_tready), 64'd0);
    check("t6_rst_fwd", 64'(fwd_count), 64'd0);
    check("t6_rst_drop", 64'(drop_count), 64'd0);
    check("t6_rst_hdata", m_udphdr_tdata, 64'd0);
    s_udpdata_tvalid = 1'b0;
    hdr_rdy_fix = '1;
    dat_rdy_fix = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("idle_after_rst2");
    send_dgram(16'h5400, 64'h0B00_0005_DDDD_0030, 2, 1'b0, 1'b0);
    wait_idle("idle_t6");
    check("t6_fwd", 64'(fwd_count), 64'd1);
    check("t6_drop", 64'(drop_count), 64'd0);
    check_sb_empty("t6_sb_empty");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
